// File: rtl/ysyx_23060025_ifu_prefetch_pkg.sv
// Shared definitions for the prefetching IFU: FSM state encodings and fetch defaults.
package ysyx_23060025_ifu_prefetch_pkg;

  typedef enum logic [1:0] {
    IFU_PF_IDLE  = 2'b00,
    IFU_PF_REQ   = 2'b01,
    IFU_PF_DRAIN = 2'b10
  } ifu_pf_state_e;

  localparam logic [31:0] IFU_PF_RESET_PC   = 32'h3000_0000;
  localparam int unsigned IFU_PF_INST_BYTES = 4;

endpackage

// File: rtl/ysyx_23060025_ifu_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate counter register.
module ysyx_23060025_ifu_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot being written, so push is legal even when full.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[IDX_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/ysyx_23060025_ifu_prefetch.sv
// Sequential-prefetch IFU: one outstanding icache read, results queued with their PC
// for the IDU; a redirect flushes the queue and restarts fetch at the new PC.
module ysyx_23060025_ifu_prefetch
  import ysyx_23060025_ifu_prefetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IFU_PF_RESET_PC)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc_i,
  output logic                          inst_valid_o,
  input  logic                          inst_ready_i,
  output logic [DATA_WIDTH-1:0]         inst_o,
  output logic [ADDR_WIDTH-1:0]         inst_pc_o,
  output logic                          out_psel,
  output logic [ADDR_WIDTH-1:0]         out_paddr,
  input  logic                          out_pready,
  input  logic [DATA_WIDTH-1:0]         out_prdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned           CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(IFU_PF_INST_BYTES);

  ifu_pf_state_e                    state;
  ifu_pf_state_e                    state_next;
  logic [ADDR_WIDTH-1:0]            fetch_pc;
  logic [ADDR_WIDTH-1:0]            drain_addr;
  logic [ADDR_WIDTH-1:0]            redirect_pc_aligned;
  logic                             push;
  logic                             pop;
  logic                             fifo_empty;
  logic [CNT_W-1:0]                 count;
  logic [CNT_W-1:0]                 count_after_push;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

  assign redirect_pc_aligned = redirect_pc_i & ~ADDR_WIDTH'(3);
  assign pop                 = inst_valid_o && inst_ready_i;
  assign count_after_push    = count + CNT_W'(1) - CNT_W'(pop);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_next = state;
    push       = 1'b0;
    unique case (state)
      IFU_PF_IDLE: begin
        if (!redirect_valid_i && count < DEPTH_C) state_next = IFU_PF_REQ;
      end
      IFU_PF_REQ: begin
        if (redirect_valid_i) begin
          state_next = out_pready ? IFU_PF_IDLE : IFU_PF_DRAIN;
        end else if (out_pready) begin
          push       = 1'b1;
          state_next = (count_after_push < DEPTH_C) ? IFU_PF_REQ : IFU_PF_IDLE;
        end
      end
      IFU_PF_DRAIN: begin
        if (out_pready) state_next = IFU_PF_IDLE;
      end
      default: state_next = IFU_PF_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IFU_PF_IDLE;
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect_valid_i) fetch_pc <= redirect_pc_aligned;
      else if (push)        fetch_pc <= fetch_pc + STEP;
      // The abandoned request must keep its address on the bus until the icache answers.
      if (state == IFU_PF_REQ && redirect_valid_i && !out_pready) drain_addr <= fetch_pc;
    end
  end

  assign out_psel  = (state != IFU_PF_IDLE);
  assign out_paddr = (state == IFU_PF_DRAIN) ? drain_addr : fetch_pc;

  ysyx_23060025_ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_WIDTH + DATA_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid_i),
    .push      (push),
    .push_data ({fetch_pc, out_prdata}),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign inst_valid_o = !fifo_empty;
  assign inst_pc_o    = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign inst_o       = head[DATA_WIDTH-1:0];
  assign fifo_count_o = count;

endmodule

// File: tb/tb_ysyx_23060025_ifu_prefetch.sv
// Directed bench for the prefetching IFU: bench-side icache model and in-order
// PC/instruction scoreboard on the IDU handshake.
module tb_ysyx_23060025_ifu_prefetch;

  logic        clock;
  logic        reset;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        out_psel;
  logic [31:0] out_paddr;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic [2:0]  fifo_count_o;

  ysyx_23060025_ifu_prefetch dut (
    .clock            (clock),
    .reset            (reset),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .out_psel         (out_psel),
    .out_paddr        (out_paddr),
    .out_pready       (out_pready),
    .out_prdata       (out_prdata),
    .fifo_count_o     (fifo_count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          auto_cache = 0;
  bit          rand_lat   = 0;
  int          lat        = 0;
  int          wait_cnt   = 0;
  bit          prev_psel  = 0;
  bit          prev_pready = 0;
  logic [31:0] prev_addr  = '0;
  bit          sb_en      = 0;
  logic [31:0] exp_pc     = '0;
  int          n_got      = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Icache model: answers each request after `lat` extra cycles of psel.
  task automatic cache_model();
    if (prev_psel && !prev_pready && out_psel) check("paddr_hold", out_paddr, prev_addr);
    if (out_psel) begin
      if (wait_cnt >= lat) begin
        out_pready = 1'b1;
        out_prdata = inst_of(out_paddr);
        wait_cnt   = 0;
        if (rand_lat) lat = $urandom_range(14, 0);
      end else begin
        out_pready = 1'b0;
        wait_cnt++;
      end
    end else begin
      out_pready = 1'b0;
      wait_cnt   = 0;
    end
    prev_psel   = out_psel;
    prev_pready = out_pready;
    prev_addr   = out_paddr;
  endtask

  task automatic cache_on(input bit random_latency);
    auto_cache = 1'b1;
    rand_lat   = random_latency;
    lat        = random_latency ? int'($urandom_range(14, 0)) : 0;
    wait_cnt   = 0;
    prev_psel  = 1'b0;
  endtask

  // One clock: score the IDU handshake on pre-edge values, then sample #1 after the edge.
  task automatic tick();
    if (sb_en && inst_valid_o && inst_ready_i) begin
      check("stream_pc", inst_pc_o, exp_pc);
      check("stream_inst", inst_o, inst_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_got++;
    end
    @(posedge clock);
    #1;
    if (auto_cache) cache_model();
  endtask

  task automatic do_reset();
    sb_en            = 1'b0;
    auto_cache       = 1'b0;
    prev_psel        = 1'b0;
    out_pready       = 1'b0;
    out_prdata       = '0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    inst_ready_i     = 1'b0;
    reset            = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int guard;

  initial begin
    // Reset state and zero-wait streaming.
    do_reset();
    check("rst_psel", out_psel, 1'b0);
    check("rst_valid", inst_valid_o, 1'b0);
    check("rst_count", fifo_count_o, 3'd0);
    check("rst_paddr", out_paddr, 32'h3000_0000);
    inst_ready_i = 1'b1;
    exp_pc = 32'h3000_0000; n_got = 0; sb_en = 1'b1;
    cache_on(1'b0);
    tick();
    check("first_psel", out_psel, 1'b1);
    check("first_paddr", out_paddr, 32'h3000_0000);
    guard = 0;
    while (n_got < 16 && guard < 100) begin tick(); guard++; end
    check("stream16_done", n_got, 16);
    check("throughput_cycles", guard, 17);
    check("pushpop_count", fifo_count_o, 3'd1);

    // Back-pressure fills the queue, then fetch resumes where it stopped.
    do_reset();
    exp_pc = 32'h3000_0000; n_got = 0; sb_en = 1'b1;
    cache_on(1'b0);
    repeat (10) tick();
    check("full_count", fifo_count_o, 3'd4);
    check("full_psel", out_psel, 1'b0);
    check("full_valid", inst_valid_o, 1'b1);
    check("full_head_pc", inst_pc_o, 32'h3000_0000);
    inst_ready_i = 1'b1;
    guard = 0;
    while (!out_psel && guard < 20) begin tick(); guard++; end
    check("resume_paddr", out_paddr, 32'h3000_0010);
    guard = 0;
    while (n_got < 8 && guard < 50) begin tick(); guard++; end
    check("resume_done", n_got, 8);

    // Redirect with a full queue and a simultaneous IDU handshake.
    inst_ready_i = 1'b0;
    repeat (12) tick();
    check("refill_count", fifo_count_o, 3'd4);
    inst_ready_i     = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h4000_0002;
    guard = n_got;
    tick();
    redirect_valid_i = 1'b0;
    check("flush_consumed", n_got, guard + 1);
    check("flush_valid", inst_valid_o, 1'b0);
    check("flush_count", fifo_count_o, 3'd0);
    exp_pc = 32'h4000_0000;
    tick();
    check("redir_idle_paddr", out_paddr, 32'h4000_0000);
    guard = 0; n_got = 0;
    while (n_got < 6 && guard < 50) begin tick(); guard++; end
    check("redir_stream_done", n_got, 6);

    // Redirect while the icache is slow: DRAIN holds the old address.
    do_reset();
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0002;
    tick();
    redirect_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drain_psel", out_psel, 1'b1);
      check("drain_paddr", out_paddr, 32'h3000_0000);
      tick();
    end
    check("drain_paddr_last", out_paddr, 32'h3000_0000);
    out_pready = 1'b1;
    out_prdata = 32'h0BAD_0BAD;
    tick();
    out_pready = 1'b0;
    check("drain_done_psel", out_psel, 1'b0);
    check("drain_discard_valid", inst_valid_o, 1'b0);
    tick();
    check("drain_new_psel", out_psel, 1'b1);
    check("drain_new_paddr", out_paddr, 32'h8000_0000);
    check("drain_new_count", fifo_count_o, 3'd0);
    out_pready = 1'b1;
    out_prdata = inst_of(32'h8000_0000);
    tick();
    out_pready = 1'b0;
    check("drain_push_pc", inst_pc_o, 32'h8000_0000);
    check("drain_push_inst", inst_o, inst_of(32'h8000_0000));

    // Redirect coincident with pready drops that response.
    do_reset();
    tick();
    out_pready       = 1'b1;
    out_prdata       = inst_of(32'h3000_0000);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_1000;
    tick();
    out_pready       = 1'b0;
    redirect_valid_i = 1'b0;
    check("coinc_valid", inst_valid_o, 1'b0);
    check("coinc_count", fifo_count_o, 3'd0);
    check("coinc_psel", out_psel, 1'b0);
    tick();
    check("coinc_paddr", out_paddr, 32'h8000_1000);
    inst_ready_i = 1'b1;
    exp_pc = 32'h8000_1000; n_got = 0; sb_en = 1'b1;
    cache_on(1'b0);
    cache_model();
    guard = 0;
    while (n_got < 4 && guard < 30) begin tick(); guard++; end
    check("coinc_stream_done", n_got, 4);

    // Random-latency icache and random IDU readiness over 1000 instructions.
    do_reset();
    exp_pc = 32'h3000_0000; n_got = 0; sb_en = 1'b1;
    cache_on(1'b1);
    guard = 0;
    while (n_got < 1000 && guard < 30000) begin
      inst_ready_i = ($urandom_range(3, 0) != 0);
      tick();
      guard++;
    end
    check("random_done", n_got, 1000);

    // Address wrap and reset in the middle of a request.
    do_reset();
    tick();
    out_pready       = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'hFFFF_FFFC;
    tick();
    out_pready       = 1'b0;
    redirect_valid_i = 1'b0;
    tick();
    check("wrap_paddr", out_paddr, 32'hFFFF_FFFC);
    out_pready = 1'b1;
    out_prdata = inst_of(32'hFFFF_FFFC);
    tick();
    out_pready = 1'b0;
    check("wrap_next_paddr", out_paddr, 32'h0000_0000);
    check("wrap_head_pc", inst_pc_o, 32'hFFFF_FFFC);
    reset = 1'b1;
    tick();
    check("midreq_rst_psel", out_psel, 1'b0);
    check("midreq_rst_valid", inst_valid_o, 1'b0);
    check("midreq_rst_paddr", out_paddr, 32'h3000_0000);
    reset = 1'b0;
    check("restart_idle_psel", out_psel, 1'b0);
    tick();
    check("restart_psel", out_psel, 1'b1);
    check("restart_paddr", out_paddr, 32'h3000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
